accumulate: RTL
===============

# accumulate

Streaming fixed-point multiply-accumulate stage that sits directly upstream of `saturate`. It consumes a stream of signed operand pairs, each terminated by a `last` beat. It forms the Q-format dot product in an ARGW-wide accumulator that clamps at its own limits, and presents one ARGW-wide result per stream for `saturate` to narrow to RESW.

## Interface
- `OPW`, 16: width of each signed operand (two's complement, FRAC fractional bits).
- `FRAC`, 8: fractional bits of operands and of result.
- `ARGW`, 24: accumulator/result width; matches `saturate` ARGW.

- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `arg_valid`  in  1  operand beat valid.
- `arg_ready`  out  1  block accepts a beat this cycle.
- `arg_data`  in  2*OPW  {a, b}; a = [2*OPW-1:OPW], b = [OPW-1:0], both signed.
- `arg_last`  in  1  beat is final element of the stream.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  ARGW  signed accumulated result.

## Operation
- States: IDLE (no stream open), ACC (stream open), DRAIN (last beat accepted, pipeline emptying), DONE (result held).
- A beat transfers when `arg_valid && arg_ready`.
- `arg_ready` = 1 in IDLE and ACC; 0 in DRAIN and DONE.
- Stage 1 (multiply): p = a*b, full 2*OPW signed, registered with a valid bit and a last bit.
- Stage 2 (scale/accumulate):
  - s = p >>> FRAC (arithmetic).
  - s is clamped to [-2^(ARGW-1), 2^(ARGW-1)-1].
  - acc_next = acc + s, computed at ARGW+1 bits and clamped to the same range. Saturating, never wraps; once clamped, later terms still add normally.
  - First beat of a stream loads acc = s, not acc + s.
- IDLE -> ACC on a non-last beat. IDLE -> DRAIN on a last beat (single-element stream).
- ACC -> DRAIN on a last beat.
- DRAIN -> DONE when stage 2 consumes the last product. `res_data` <= final acc and `res_valid` <= 1.
- DONE -> IDLE on `res_valid && res_ready`.
- `res_data` is stable while `res_valid && !res_ready`.
- `arg_valid` while `arg_ready` = 0 is ignored; upstream must hold the beat.
- Back-to-back beats within a stream are accepted every cycle; no bubbles are required.

## Timing
- Reset values: `arg_ready` = 1, `res_valid` = 0, `res_data` = 0, acc = 0, pipeline valids = 0, state IDLE.
- Reset is asserted asynchronously and released synchronously to `clock` by the system.
- Reset mid-stream discards all partial state; the next beat after release starts a new stream.
- Latency: last beat accepted at edge N -> `res_valid` = 1 after edge N+2.
- The result handshake at edge M returns `arg_ready` to 1 after edge M. A new stream's first beat can transfer at edge M+1.
- Throughput: one beat per cycle within a stream. Per-stream overhead is 3 cycles minimum (DRAIN, DONE, handshake).
- `arg_ready` is a registered-state decode and has no combinational path from `res_ready`.

## Configuration
- `ACCUMULATE_ROUND_EN` defined: s = (p + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +inf, with the addition done at 2*OPW+1 bits.
- Not defined: s = p >>> FRAC, i.e. truncation toward -inf.
- The macro has no effect on state machine, latency or handshake.

## Test plan
All scenarios use defaults OPW=16, FRAC=8, ARGW=24.
- Single-beat stream {0x0200, 0x0300} with last -> `res_data` = 0x000600, `res_valid` 2 cycles after acceptance.
- Three-beat stream {0x0100,0x0100}, {0x0100,0xFF00}, {0x0080,0x0200} with last on the third -> 0x000100.
- Positive overflow: three beats {0x7FFF,0x7FFF} -> 0x7FFFFF.
- Negative overflow: three beats {0x8000,0x7FFF} -> 0x800000.
- Backpressure: hold `res_ready` = 0 for 5 cycles after `res_valid`:
  - `res_data` stays 0x000600 and `arg_ready` stays 0.
  - After the handshake, the next stream {0x0100,0x0100} -> 0x000100.
- Reset mid-stream: assert `reset` low after 2 of 3 beats, release, send {0x0100,0x0100} with last -> 0x000100, with no residue.
- Rounding: {0x0001,0x0080} with last -> 0x000000 without `ACCUMULATE_ROUND_EN`, 0x000001 with it.

Source files
------------

// File: rtl/accumulate.sv
// Streaming signed multiply-accumulate feeding `saturate`: one clamped ARGW-wide dot product per stream.
// Define ACCUMULATE_ROUND_EN to round each scaled product half toward +inf instead of truncating.
module accumulate #(
    parameter int OPW  = 16,
    parameter int FRAC = 8,
    parameter int ARGW = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arg_valid,
    output logic                   arg_ready,
    input  logic [2*OPW-1:0]       arg_data,
    input  logic                   arg_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [ARGW-1:0] res_data
);

    localparam int PW = 2 * OPW;
    // Working width holds a full product plus rounding carry and an ARGW+1 accumulator sum.
    localparam int XW = (PW + 1 > ARGW + 1) ? PW + 1 : ARGW + 1;

    localparam logic signed [XW-1:0] ACC_MAX = {{(XW-ARGW+1){1'b0}}, {(ARGW-1){1'b1}}};
    localparam logic signed [XW-1:0] ACC_MIN = {{(XW-ARGW+1){1'b1}}, {(ARGW-1){1'b0}}};
`ifdef ACCUMULATE_ROUND_EN
    localparam logic signed [XW-1:0] ROUND_HALF = XW'(1) << (FRAC - 1);
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACC   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic signed [XW-1:0] sext_prod(input logic signed [PW-1:0] v);
        return {{(XW-PW){v[PW-1]}}, v};
    endfunction

    function automatic logic signed [XW-1:0] sext_acc(input logic signed [ARGW-1:0] v);
        return {{(XW-ARGW){v[ARGW-1]}}, v};
    endfunction

    function automatic logic signed [ARGW-1:0] clamp(input logic signed [XW-1:0] v);
        logic signed [ARGW-1:0] r;
        if (v > ACC_MAX) begin
            r = ACC_MAX[ARGW-1:0];
        end else if (v < ACC_MIN) begin
            r = ACC_MIN[ARGW-1:0];
        end else begin
            r = v[ARGW-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [ARGW-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [XW-1:0] x;
        x = sext_prod(p);
`ifdef ACCUMULATE_ROUND_EN
        x = x + ROUND_HALF;
`endif
        return clamp(x >>> FRAC);
    endfunction

    logic [1:0] state;
    logic       take;

    logic signed [OPW-1:0] op_a;
    logic signed [OPW-1:0] op_b;
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;

    logic signed [PW-1:0]   prod_p1;
    logic                   vld_p1;
    logic                   last_p1;
    logic                   first_p1;

    logic signed [ARGW-1:0] scaled_p1;
    logic signed [ARGW-1:0] sum_p1;
    logic signed [ARGW-1:0] acc_p2;
    logic                   last_p2;

    // arg_ready decodes registered state only, so res_ready never reaches it combinationally.
    assign arg_ready = (state == IDLE) || (state == ACC);
    assign take      = arg_valid && arg_ready;

    assign op_a  = arg_data[PW-1:OPW];
    assign op_b  = arg_data[OPW-1:0];
    assign a_ext = {{OPW{op_a[OPW-1]}}, op_a};
    assign b_ext = {{OPW{op_b[OPW-1]}}, op_b};

    // ---- stage 1: multiply ----
    always_ff @(posedge clock) begin
        if (take) begin
            prod_p1 <= a_ext * b_ext;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            first_p1 <= 1'b0;
        end else begin
            vld_p1   <= take;
            last_p1  <= take && arg_last;
            first_p1 <= take && (state == IDLE);
        end
    end

    // ---- stage 2: scale and saturating accumulate ----
    assign scaled_p1 = scale(prod_p1);
    assign sum_p1    = clamp(sext_acc(acc_p2) + sext_acc(scaled_p1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_p2  <= '0;
            last_p2 <= 1'b0;
        end else begin
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                acc_p2 <= first_p1 ? scaled_p1 : sum_p1;
            end
        end
    end

    // ---- stage 3: stream control and result register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state <= arg_last ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (take && arg_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_p2) begin
                        res_data  <= acc_p2;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
